// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and execute-unit FSM encoding
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_BGEZ = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BGTZ = 4'd12;
    localparam logic [3:0] ALU_BLEZ = 4'd13;
    localparam logic [3:0] ALU_BLTZ = 4'd14;
    localparam logic [3:0] ALU_RSVD = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } alu_state_t;

    function automatic logic alu_is_mul(input logic [3:0] code);
        return code == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - iterative shift-add multiplier, low 32 bits of A*B
// Optional early exit when the remaining multiplier is zero: MUL_EARLY_TERM_EN.
module alu_seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [4:0]       r_cnt;
    logic             r_busy;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
    // Once the shifted multiplier is empty no further partial products can add in.
    assign w_last = (r_cnt == 5'd31) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    assign busy    = r_busy;
    assign done    = r_busy && w_last;
    assign product = w_acc_next;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= A;
            r_mplier <= B;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
            r_cnt    <= r_cnt + 5'd1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and multi-cycle mul
// MUL_EARLY_TERM_EN shortens multiplies by operand B magnitude; results are unchanged.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             BranchTaken
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_branch;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_mul_bypass;
    logic             w_take_mul;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_branch;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic             w_a_neg;
    logic             w_a_zero;

`ifdef MUL_EARLY_TERM_EN
    assign w_mul_bypass = (B == '0);
`else
    assign w_mul_bypass = 1'b0;
`endif

    assign w_take_mul = alu_is_mul(ALUControl) && !w_mul_bypass;
    assign w_a_neg    = A[WIDTH-1];
    assign w_a_zero   = (A == '0);

    always_comb begin
        w_alu_result = '0;
        w_branch     = 1'b0;
        case (ALUControl)
            ALU_ADD:  w_alu_result = A + B;
            ALU_SUB: begin
                w_alu_result = A - B;
                w_branch     = (A == B);
            end
            ALU_AND:  w_alu_result = A & B;
            ALU_OR:   w_alu_result = A | B;
            ALU_NOR:  w_alu_result = ~(A | B);
            ALU_XOR:  w_alu_result = A ^ B;
            ALU_SLL:  w_alu_result = B << Shamt;
            ALU_SRL:  w_alu_result = B >> Shamt;
            ALU_MUL:  w_alu_result = '0;
            ALU_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_BGEZ: w_branch = !w_a_neg;
            ALU_BNE:  w_branch = (A != B);
            ALU_BGTZ: w_branch = !w_a_neg && !w_a_zero;
            ALU_BLEZ: w_branch = w_a_neg || w_a_zero;
            ALU_BLTZ: w_branch = w_a_neg;
            default: begin
                w_alu_result = '0;
                w_branch     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = 1'b1;
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                w_in_ready  = OutReady;
                if (OutReady && !InValid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!Reset) begin
            w_in_ready = 1'b0;
        end
        w_accept = InValid && w_in_ready;
        if (w_accept) begin
            w_state_next = w_take_mul ? S_MUL : S_HOLD;
        end
    end

    // Output registers move only when a result lands, so HOLD keeps them stable.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_result <= '0;
            r_branch <= 1'b0;
        end else if (w_accept && !w_take_mul) begin
            r_result <= w_alu_result;
            r_branch <= w_branch;
        end else if (r_state == S_MUL && w_mul_done) begin
            r_result <= w_mul_product;
            r_branch <= 1'b0;
        end
    end

    alu_seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (w_accept && w_take_mul),
        .A      (A),
        .B      (B),
        .busy   (w_mul_busy),
        .done   (w_mul_done),
        .product(w_mul_product)
    );

    assign InReady     = w_in_ready;
    assign OutValid    = w_out_valid && !(r_state == S_MUL && w_mul_busy);
    assign Result      = r_result;
    assign Zero        = (r_result == '0);
    assign BranchTaken = r_branch;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Zero;
    logic        BranchTaken;

    int n_total = 0;
    int n_bad   = 0;

`ifdef MUL_EARLY_TERM_EN
    localparam int MUL_LAT_FFX3 = 3;
`else
    localparam int MUL_LAT_FFX3 = 33;
`endif

    alu_exec_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Shamt      (Shamt),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Result     (Result),
        .Zero       (Zero),
        .BranchTaken(BranchTaken)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        ALUControl = c;
        A          = a;
        B          = b;
        Shamt      = s;
        InValid    = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s,
                          input logic [31:0] exp_r, input logic exp_br);
        int n;
        issue(c, a, b, s);
        tick;
        InValid = 1'b0;
        n = 1;
        while (!OutValid && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({tag, "_res"}, Result, exp_r);
        chk({tag, "_br"}, 32'(BranchTaken), 32'(exp_br));
        chk({tag, "_zero"}, 32'(Zero), 32'(exp_r == 32'd0));
        tick;
    endtask

    initial begin : main
        int  lat;
        logic ready_seen;

        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ALUControl = 4'd0; A = '0; B = '0; Shamt = '0;

        // reset for two cycles
        tick;
        chk("rst_inready_low", 32'(InReady), 32'd0);
        tick;
        Reset = 1'b1;
        #1;
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_branch", 32'(BranchTaken), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);

        // back-to-back, zero bubble
        @(negedge Clk);
        issue(4'd0, 32'd5, 32'd7, 5'd0);
        tick;
        chk("b2b_add_valid", 32'(OutValid), 32'd1);
        chk("b2b_add_res", Result, 32'd12);
        chk("b2b_inready", 32'(InReady), 32'd1);
        issue(4'd1, 32'd3, 32'd3, 5'd0);
        tick;
        chk("b2b_sub_res", Result, 32'd0);
        chk("b2b_sub_zero", 32'(Zero), 32'd1);
        chk("b2b_sub_br", 32'(BranchTaken), 32'd1);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
        tick;
        chk("b2b_slt_res", Result, 32'd1);
        chk("b2b_slt_br", 32'(BranchTaken), 32'd0);
        InValid = 1'b0;
        tick;
        chk("b2b_drain", 32'(OutValid), 32'd0);

        // mul latency and InReady during MUL
        issue(4'd8, 32'hFFFF_FFFF, 32'd3, 5'd0);
        tick;
        InValid = 1'b0;
        lat = 1;
        ready_seen = 1'b0;
        while (!OutValid && lat < 100) begin
            if (InReady) ready_seen = 1'b1;
            tick;
            lat++;
        end
        chk("mul_latency", 32'(lat), 32'(MUL_LAT_FFX3));
        chk("mul_res", Result, 32'hFFFF_FFFD);
        chk("mul_inready_low", 32'(ready_seen), 32'd0);
        tick;

        run_op("mul_7x6", 4'd8, 32'd7, 32'd6, 5'd0, 32'd42, 1'b0);
        run_op("mul_b0", 4'd8, 32'h1234_5678, 32'd0, 5'd0, 32'd0, 1'b0);
        run_op("mul_big", 4'd8, 32'h0001_0001, 32'h0001_0001, 5'd0, 32'h0002_0001, 1'b0);

        // single-cycle ops and branches
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0);
        run_op("sub_neg", 4'd1, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0);
        run_op("and", 4'd2, 32'hF0F0, 32'h0FF0, 5'd0, 32'h00F0, 1'b0);
        run_op("or", 4'd3, 32'hF0F0, 32'h0FF0, 5'd0, 32'hFFF0, 1'b0);
        run_op("nor", 4'd4, 32'hF0F0, 32'h0FF0, 5'd0, 32'hFFFF_000F, 1'b0);
        run_op("sll31", 4'd6, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
        run_op("srl31", 4'd7, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 1'b0);
        run_op("slt_no", 4'd9, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
        run_op("slt_min", 4'd9, 32'h8000_0000, 32'd0, 5'd0, 32'd1, 1'b0);
        run_op("bltz", 4'd14, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 1'b1);
        run_op("bgez", 4'd10, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 1'b0);
        run_op("blez", 4'd13, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 1'b1);
        run_op("bgtz", 4'd12, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 1'b0);
        run_op("bne_eq", 4'd11, 32'd9, 32'd9, 5'd0, 32'd0, 1'b0);
        run_op("bne_ne", 4'd11, 32'd9, 32'd8, 5'd0, 32'd0, 1'b1);
        run_op("bgtz_pos", 4'd12, 32'd5, 32'd0, 5'd0, 32'd0, 1'b1);
        run_op("bgez_0", 4'd10, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        run_op("blez_pos", 4'd13, 32'd1, 32'd0, 5'd0, 32'd0, 1'b0);
        run_op("beq_ne", 4'd1, 32'd4, 32'd3, 5'd0, 32'd1, 1'b0);
        run_op("rsvd", 4'd15, 32'd5, 32'd5, 5'd3, 32'd0, 1'b0);

        // backpressure: outputs hold, new input ignored until OutReady
        OutReady = 1'b0;
        issue(4'd5, 32'hF0F0, 32'h0FF0, 5'd0);
        tick;
        issue(4'd0, 32'd1, 32'd1, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_res_%0d", i), Result, 32'hFF00);
            chk($sformatf("bp_valid_%0d", i), 32'(OutValid), 32'd1);
            chk($sformatf("bp_inready_%0d", i), 32'(InReady), 32'd0);
            tick;
        end
        OutReady = 1'b1;
        #1;
        chk("bp_release_inready", 32'(InReady), 32'd1);
        tick;
        chk("bp_new_res", Result, 32'd2);
        chk("bp_new_valid", 32'(OutValid), 32'd1);
        InValid = 1'b0;
        tick;

        // reset in the middle of a multiply
        issue(4'd8, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0);
        tick;
        InValid = 1'b0;
        repeat (9) tick;
        chk("mid_busy", 32'(OutValid), 32'd0);
        Reset = 1'b0;
        tick;
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(OutValid), 32'd0);
        chk("mid_rst_res", Result, 32'd0);
        chk("mid_rst_zero", 32'(Zero), 32'd1);
        chk("mid_rst_inready", 32'(InReady), 32'd1);
        @(negedge Clk);
        run_op("post_rst_mul", 4'd8, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller, together with the two register operands and the shift amount, and returns a registered 32-bit result plus zero and branch-taken flags. Single-cycle operations complete one cycle after acceptance. Multiply (code 8) runs on an iterative shift-add engine over several cycles. Valid/ready handshakes on both sides let the pipeline stall around the multi-cycle multiply.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- InValid  in  1  upstream presents an operation.
- InReady  out  1  unit can accept; transfer when InValid && InReady.
- ALUControl  in  4  operation code, encodings below.
- A  in  32  operand A (rs).
- B  in  32  operand B (rt or immediate).
- Shamt  in  5  shift amount for sll/srl.
- OutValid  out  1  result registers hold a completed operation.
- OutReady  in  1  downstream consumes; transfer when OutValid && OutReady.
- Result  out  32  operation result.
- Zero  out  1  Result == 0.
- BranchTaken  out  1  branch condition true (codes 1, 10–14 only).

## Operation
- Codes: 0 add, 1 sub/beq, 2 and, 3 or, 4 nor, 5 xor, 6 sll (B<<Shamt), 7 srl (B>>Shamt, logical), 8 mul, 9 slt (signed A<B → 1 else 0), 10 bgez, 11 bne, 12 bgtz, 13 blez, 14 bltz, 15 reserved.
- Arithmetic wraps modulo 2^32; no overflow flag. mul returns the low 32 bits of A*B, which is identical for signed and unsigned operands.
- BranchTaken: code 1 → A==B; 11 → A!=B; 10 → $signed(A)>=0; 12 → >0; 13 → <=0; 14 → <0. BranchTaken is 0 for all other codes.
- Result for code 1 is A−B. Result for codes 10–14 and for code 15 is 0, so Zero=1 and BranchTaken=0 for code 15.
- The operation is captured in full at acceptance. Later changes on A, B, Shamt or ALUControl have no effect.
- FSM states:
  - IDLE: InReady=1, OutValid=0. On accept, a non-mul op computes combinationally into the output registers and moves to HOLD. A mul loads acc=0, mcand=A, mplier=B, cnt=0 and moves to MUL.
  - MUL: InReady=0. Each cycle: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++. After the cycle with cnt==31, Result=acc and the state moves to HOLD.
  - HOLD: OutValid=1. InReady=OutReady. On OutReady without InValid, go to IDLE. On OutReady with InValid, accept the new op in the same edge (back-to-back, zero bubble). Without OutReady, hold all outputs stable.
- Reset (Reset==0 at an edge), including mid-multiply, aborts the operation and returns to IDLE with all outputs cleared.

## Timing
- Reset values: InReady=0 during reset, 1 in the first cycle after; OutValid=0, Result=0, Zero=1, BranchTaken=0; acc/mcand/mplier/cnt=0.
- Non-mul latency: accepted at edge t, OutValid=1 in the cycle following t.
- Mul latency: 32 MUL cycles, so OutValid appears 33 cycles after acceptance. Maximum sustained throughput is one mul per 33 cycles.
- Non-mul sustained throughput is one op per cycle while OutReady=1.
- Output registers change only when a result is produced or on reset.

## Configuration
- MUL_EARLY_TERM_EN defined: MUL exits to HOLD at the first edge where the shifted mplier becomes 0, or when cnt==31, whichever comes first. Mul with B==0 bypasses MUL and has latency 1; B==1 has latency 2; latency is 1 + (index of B's highest set bit + 1).
- Undefined: fixed 32-cycle MUL phase for every mul, latency 33 regardless of operands.
- Result values are identical in both builds.

## Structure
- Shared package alu_pkg:
  - localparams for all 16 ALUControl codes (ALU_ADD … ALU_BLTZ, ALU_RSVD), shared with the ALU controller.
  - FSM state encoding (S_IDLE, S_MUL, S_HOLD).
- Sub-module alu_seq_multiplier holds acc/mcand/mplier/cnt and the early-termination logic.
  - Interface: start, A, B in; busy, done, product out.
  - The top owns the handshake FSM and single-cycle datapath.

## Test plan
- Reset for 2 cycles, then release → OutValid=0, Result=0, Zero=1, InReady=1. Assert Reset mid-mul at cycle 10 → IDLE next cycle with outputs cleared.
- Back-to-back with OutReady=1: add 5+7, then sub 3−3, then slt −1<1 → Result 12, 0 (Zero=1, BranchTaken=1), then 1, on three consecutive cycles.
- mul 0xFFFFFFFF×3 → Result 0xFFFFFFFD. Latency 33 without the macro, 3 with MUL_EARLY_TERM_EN. InReady=0 throughout MUL.
- Branches with A=0x80000000: bltz → 1, bgez → 0, blez → 1, bgtz → 0. bne with A=B=9 → 0. Result=0 for codes 10–14.
- Backpressure: hold OutReady=0 for 5 cycles after xor 0xF0F0^0x0FF0 → Result 0xFF00 stays stable, InReady=0, and the input change is ignored. Raising OutReady with InValid → the new op is accepted in the same edge.
- Shifts: sll B=1, Shamt=31 → 0x80000000; srl B=0x80000000, Shamt=31 → 1. Code 15 → Result 0, Zero=1.
